// File: rtl/imem_if.sv
// imem_if -- fetch/load bundle between an instruction-memory initiator and
// the imem_responder.
//
// Signals (names are from the responder's point of view):
//   req_i      fetch request
//   addr_i     32-bit byte address of the fetch
//   ready_o    responder can accept a fetch this cycle
//   rvalid_o   one-cycle pulse: rdata_o/err_o carry a response
//   rdata_o    fetched instruction word
//   err_o      response was for a misaligned or out-of-range address
//   ld_en_i    load-port write enable
//   ld_addr_i  load-port word address
//   ld_data_i  load-port write data
//
// Modports: master = core / boot loader side, slave = responder side.
interface imem_if #(
   parameter int ADDR_W = 10
);
   logic              req_i;
   logic [31:0]       addr_i;
   logic              ready_o;
   logic              rvalid_o;
   logic [31:0]       rdata_o;
   logic              err_o;
   logic              ld_en_i;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [31:0]       ld_data_i;

   modport master (
      output req_i, addr_i, ld_en_i, ld_addr_i, ld_data_i,
      input  ready_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, addr_i, ld_en_i, ld_addr_i, ld_data_i,
      output ready_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/imem_responder.sv
// imem_responder -- memory-side end of the RISC-V Lite instruction-fetch
// protocol. Accepts word fetches, reads a 2^ADDR_W x 32 synchronous array and
// returns the word LATENCY cycles after acceptance with a one-cycle rvalid_o
// pulse. Misaligned or out-of-range fetches return NOP_WORD with err_o=1 and
// do not touch the array. A side-band load port fills the array; while it is
// writing, ready_o is held low so a fetch and a load never share an edge.
//
// Ports:
//   CLK    clock, rising edge
//   RST_n  asynchronous active-low reset (array contents are not reset)
//   bus    imem_if.slave: req_i/addr_i/ready_o fetch handshake,
//          rvalid_o/rdata_o/err_o response, ld_en_i/ld_addr_i/ld_data_i load
//
// Parameters:
//   ADDR_W    word-address width (must match the interface)
//   LATENCY   accept-to-rvalid_o latency in cycles, 1..8
//   NOP_WORD  word returned for faulting fetches (addi x0,x0,0)
//
// Build option:
//   IMEM_PIPE_EN  defined   -> LATENCY-deep pipeline, one fetch per cycle
//                 undefined -> blocking FSM, one outstanding fetch at most
module imem_responder #(
   parameter int          ADDR_W   = 10,
   parameter int          LATENCY  = 2,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic   CLK,
   input  logic   RST_n,
   imem_if.slave  bus
);

   // ------------------------------------------------------------------
   // Address decode of the incoming request
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] req_idx;
   logic              req_err;

   assign req_idx = bus.addr_i[ADDR_W+1:2];
   assign req_err = (|bus.addr_i[31:ADDR_W+2]) | (|bus.addr_i[1:0]);

   // ------------------------------------------------------------------
   // Word array and load port
   // ------------------------------------------------------------------
   logic [31:0] mem [2**ADDR_W];

   // NOTE: the array has no reset on purpose; contents loaded before reset
   // must survive it, and a reset would also block RAM inference.
   always_ff @(posedge CLK) begin
      if (bus.ld_en_i) begin
         mem[bus.ld_addr_i] <= bus.ld_data_i;
      end
   end

`ifdef IMEM_PIPE_EN
   // ------------------------------------------------------------------
   // Pipelined build: the array is read at acceptance (stage 0) and the
   // result walks down a LATENCY-deep valid/data/err shift register.
   // Data stages only advance behind a valid, so the last stage keeps the
   // previous response while rvalid_o is low.
   // ------------------------------------------------------------------
   logic [LATENCY-1:0] pv;
   logic [LATENCY-1:0] pe;
   logic [31:0]        pd [LATENCY];
   logic               accept;

   assign bus.ready_o = !bus.ld_en_i;
   assign accept      = bus.req_i && !bus.ld_en_i;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         pv <= '0;
         pe <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pd[i] <= NOP_WORD;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage sample the
         // pre-edge value of its neighbour, so the shift is order-free.
         pv[0] <= accept;
         if (accept) begin
            pd[0] <= req_err ? NOP_WORD : mem[req_idx];
            pe[0] <= req_err;
         end
         for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) begin
               pd[i] <= pd[i-1];
               pe[i] <= pe[i-1];
            end
         end
      end
   end

   assign bus.rvalid_o = pv[LATENCY-1];
   assign bus.rdata_o  = pd[LATENCY-1];
   assign bus.err_o    = pe[LATENCY-1];

`else
   // ------------------------------------------------------------------
   // Blocking build: IDLE -> WAIT (LATENCY-1 cycles) -> RESP.
   // RESP may accept the next fetch directly (back-to-back).
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   state_t            state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic              ready;
   logic              accept;
   logic [ADDR_W-1:0] idx_q;
   logic              err_q;
   logic [ADDR_W-1:0] rd_idx;
   logic              rd_err;
   logic [31:0]       rdata_q;
   logic              err_r;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_n = state;
      cnt_n   = cnt;
      ready   = 1'b0;
      accept  = 1'b0;
      case (state)
         S_IDLE, S_RESP: begin
            ready  = !bus.ld_en_i;
            accept = bus.req_i && ready;
            if (accept) begin
               if (LATENCY == 1) begin
                  state_n = S_RESP;
               end else begin
                  state_n = S_WAIT;
                  cnt_n   = CNT_INIT;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_WAIT: begin
            // cnt counts the edges still to go; the last one lands in RESP.
            cnt_n = cnt - 3'd1;
            if (cnt <= 3'd1) begin
               state_n = S_RESP;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // With LATENCY=1 the array is read on the accept edge itself, so the
   // live request is used instead of the captured one.
   assign rd_idx = (LATENCY == 1) ? req_idx : idx_q;
   assign rd_err = (LATENCY == 1) ? req_err : err_q;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= NOP_WORD;
         err_r   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            idx_q <= req_idx;
            err_q <= req_err;
         end
         // Response registers only load on entry to RESP and hold otherwise.
         if (state_n == S_RESP) begin
            rdata_q <= rd_err ? NOP_WORD : mem[rd_idx];
            err_r   <= rd_err;
         end
      end
   end

   assign bus.ready_o  = ready;
   assign bus.rvalid_o = (state == S_RESP);
   assign bus.rdata_o  = rdata_q;
   assign bus.err_o    = err_r;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder -- directed testbench for imem_responder.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge in between. Expected values are hand-derived
// constants. Build with IMEM_PIPE_EN defined to exercise the pipelined mode.
module tb_imem_responder;

   localparam int          ADDR_W   = 10;
   localparam int          LAT      = 2;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic CLK;
   logic RST_n;
   int   checks;
   int   errors;

   imem_if #(.ADDR_W(ADDR_W)) bus ();

   imem_responder #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LAT),
      .NOP_WORD(NOP_WORD)
   ) dut (
      .CLK  (CLK),
      .RST_n(RST_n),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (no comparisons inside)
   // ------------------------------------------------------------------
   task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge CLK);
      bus.ld_en_i   = 1'b1;
      bus.ld_addr_i = a;
      bus.ld_data_i = d;
      @(negedge CLK);
      bus.ld_en_i   = 1'b0;
   endtask

   // Called on the falling edge right after the accept edge. lat is the
   // number of that falling edge (1 = first) on which rvalid_o is seen, or
   // -1 if none arrives; single reports that the pulse lasted one cycle.
   task automatic wait_resp(output logic [31:0] d, output logic e,
                            output int lat, output logic single);
      lat    = -1;
      d      = '0;
      e      = 1'b0;
      single = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (bus.rvalid_o) begin
            lat = n;
            d   = bus.rdata_o;
            e   = bus.err_o;
            break;
         end
         @(negedge CLK);
      end
      if (lat > 0) begin
         @(negedge CLK);
         single = !bus.rvalid_o;
      end
   endtask

   // One fetch from idle; addr_i is scrambled after acceptance.
   task automatic do_fetch(input logic [31:0] a, output logic [31:0] d,
                           output logic e, output int lat, output logic single);
      @(negedge CLK);
      bus.req_i  = 1'b1;
      bus.addr_i = a;
      @(negedge CLK);
      bus.req_i  = 1'b0;
      bus.addr_i = 32'hFFFF_FFFF;
      wait_resp(d, e, lat, single);
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      RST_n         = 1'b1;
      bus.req_i     = 1'b0;
      bus.addr_i    = '0;
      bus.ld_en_i   = 1'b0;
      bus.ld_addr_i = '0;
      bus.ld_data_i = '0;
      #1 RST_n = 1'b0;
      #12;
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o);
      end
      checks++;
      if (bus.rvalid_o !== 1'b0) begin
         errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid_o);
      end
      checks++;
      if (bus.rdata_o !== NOP_WORD) begin
         errors++; $display("FAIL reset_rdata: got %h expected %h", bus.rdata_o, NOP_WORD);
      end
      checks++;
      if (bus.err_o !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o);
      end
      @(negedge CLK);
      RST_n = 1'b1;
   endtask

   task automatic test_fetch();
      logic [31:0] d;
      logic        e, single;
      int          lat;
      load_word(10'd5, 32'h00A0_0093);
      do_fetch(32'h0000_0014, d, e, lat, single);
      checks++;
      if (lat != LAT) begin
         errors++; $display("FAIL fetch_latency: got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (d !== 32'h00A0_0093) begin
         errors++; $display("FAIL fetch_data: got %h expected 00a00093", d);
      end
      checks++;
      if (e !== 1'b0) begin
         errors++; $display("FAIL fetch_err: got %b expected 0", e);
      end
      checks++;
      if (single !== 1'b1) begin
         errors++; $display("FAIL fetch_pulse_width: one_cycle=%b expected 1", single);
      end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      logic        e, single;
      int          lat;
      // Word 0 holds a non-NOP value so an out-of-range fetch that wrongly
      // reads index 0 is visible.
      load_word(10'd0, 32'h1234_5678);
      do_fetch(32'h0000_0016, d, e, lat, single);
      checks++;
      if (lat != LAT || d !== NOP_WORD) begin
         errors++; $display("FAIL misaligned_data: got %h lat %0d expected %h lat %0d", d, lat, NOP_WORD, LAT);
      end
      checks++;
      if (e !== 1'b1) begin
         errors++; $display("FAIL misaligned_err: got %b expected 1", e);
      end
      do_fetch(32'h0000_1000, d, e, lat, single);
      checks++;
      if (lat != LAT || d !== NOP_WORD) begin
         errors++; $display("FAIL range_data: got %h lat %0d expected %h lat %0d", d, lat, NOP_WORD, LAT);
      end
      checks++;
      if (e !== 1'b1) begin
         errors++; $display("FAIL range_err: got %b expected 1", e);
      end
      // One cycle after the pulse the response must still be held.
      checks++;
      if (bus.rdata_o !== NOP_WORD || bus.err_o !== 1'b1) begin
         errors++; $display("FAIL hold_after_pulse: got %h/%b expected %h/1", bus.rdata_o, bus.err_o, NOP_WORD);
      end
   endtask

   task automatic test_back_to_back();
`ifdef IMEM_PIPE_EN
      localparam int N = 8;
`else
      localparam int N = 3;
`endif
      int          issued, n_pulse, wait_cycles, wait_bad;
      logic        will;
      int          pt [8];
      logic [31:0] pdat [8];
      for (int i = 0; i < N; i++) begin
         load_word(10'(i), 32'hC0DE_0000 | 32'(i));
      end
      issued = 0; n_pulse = 0; wait_cycles = 0; wait_bad = 0; will = 1'b0;
      for (int t = 0; t < 24; t++) begin
         @(negedge CLK);
         if (bus.rvalid_o && n_pulse < 8) begin
            pt[n_pulse]   = t;
            pdat[n_pulse] = bus.rdata_o;
            n_pulse++;
         end
         if (will) issued++;
`ifndef IMEM_PIPE_EN
         // A request is outstanding and no response yet: the FSM is in WAIT.
         if (issued > n_pulse && !bus.rvalid_o) begin
            wait_cycles++;
            if (bus.ready_o !== 1'b0) wait_bad++;
         end
`endif
         bus.req_i  = (issued < N);
         bus.addr_i = 32'(issued * 4);
         will       = bus.req_i && bus.ready_o;
      end
      bus.req_i = 1'b0;
      checks++;
      if (n_pulse != N) begin
         errors++; $display("FAIL b2b_pulse_count: got %0d expected %0d", n_pulse, N);
      end
      for (int i = 0; i < N; i++) begin
         if (i < n_pulse) begin
            checks++;
`ifdef IMEM_PIPE_EN
            if (pt[i] != LAT + i) begin
               errors++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, pt[i], LAT + i);
            end
`else
            if (pt[i] != LAT * (i + 1)) begin
               errors++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, pt[i], LAT * (i + 1));
            end
`endif
            checks++;
            if (pdat[i] !== (32'hC0DE_0000 | 32'(i))) begin
               errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, pdat[i], 32'hC0DE_0000 | 32'(i));
            end
         end
      end
`ifndef IMEM_PIPE_EN
      checks++;
      if (wait_bad != 0 || wait_cycles != N * (LAT - 1)) begin
         errors++; $display("FAIL b2b_ready_in_wait: ready high %0d times, %0d wait cycles expected %0d", wait_bad, wait_cycles, N * (LAT - 1));
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic        e, single;
      int          lat, seen;
      @(negedge CLK);
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_0014;
      @(negedge CLK);
      bus.req_i  = 1'b0;
      RST_n      = 1'b0;
      seen       = 0;
      @(negedge CLK);
      RST_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         if (bus.rvalid_o) seen++;
         if (t < 5) @(negedge CLK);
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL reset_drop: got %0d rvalid cycles expected 0", seen);
      end
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.ready_o);
      end
      do_fetch(32'h0000_0014, d, e, lat, single);
      checks++;
      if (lat != LAT || d !== 32'h00A0_0093) begin
         errors++; $display("FAIL reset_keeps_array: got %h lat %0d expected 00a00093 lat %0d", d, lat, LAT);
      end
   endtask

   task automatic test_load_stall();
      logic [31:0] d;
      logic        e, single;
      int          lat;
      load_word(10'd8, 32'h0BAD_0BAD);
      @(negedge CLK);
      bus.ld_en_i   = 1'b1;
      bus.ld_addr_i = 10'd8;
      bus.ld_data_i = 32'hFEED_F00D;
      bus.req_i     = 1'b1;
      bus.addr_i    = 32'h0000_0020;
      #1;
      checks++;
      if (bus.ready_o !== 1'b0) begin
         errors++; $display("FAIL stall_ready_low: got %b expected 0", bus.ready_o);
      end
      @(negedge CLK);
      bus.ld_en_i = 1'b0;
      #1;
      // Still ready means the request was not taken during the load.
      checks++;
      if (bus.ready_o !== 1'b1 || bus.rvalid_o !== 1'b0) begin
         errors++; $display("FAIL stall_no_accept: ready %b rvalid %b expected 1/0", bus.ready_o, bus.rvalid_o);
      end
      @(negedge CLK);
      bus.req_i  = 1'b0;
      bus.addr_i = 32'hFFFF_FFFF;
      wait_resp(d, e, lat, single);
      checks++;
      if (lat != LAT) begin
         errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (d !== 32'hFEED_F00D || e !== 1'b0) begin
         errors++; $display("FAIL stall_fresh_data: got %h/%b expected feedf00d/0", d, e);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fetch();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_load_stall();
      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
